// File: rtl/ysyx_24100005_mem_arbiter_if.sv
// Bundle of IFU, LSU and shared-memory handshake signals for the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding CPU/memory view.
interface ysyx_24100005_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          ifu_req_valid;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_rsp_valid;
  logic [DW-1:0] ifu_rsp_data;

  logic          lsu_req_valid;
  logic          lsu_req_ready;
  logic          lsu_wen;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic [7:0]    lsu_wmask;
  logic          lsu_rsp_valid;
  logic [DW-1:0] lsu_rsp_data;

  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wmask;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto one memory port, one outstanding transaction.
// Define ROUND_ROBIN_EN for alternating tie-break; default is fixed LSU priority.
module ysyx_24100005_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  ysyx_24100005_mem_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q;
  logic          gnt_lsu_q;
  logic          mem_req_valid_q;
  logic          mem_wen_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [7:0]    mem_wmask_q;
  logic          grant_ifu_s;
  logic          grant_lsu_s;
`ifdef ROUND_ROBIN_EN
  logic          last_lsu_q;
`endif

  // Grant selection, only meaningful while idle
  always_comb begin
    grant_ifu_s = 1'b0;
    grant_lsu_s = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.ifu_req_valid && bus.lsu_req_valid) begin
`ifdef ROUND_ROBIN_EN
        grant_lsu_s = !last_lsu_q;
`else
        grant_lsu_s = 1'b1;
`endif
        grant_ifu_s = !grant_lsu_s;
      end else begin
        grant_lsu_s = bus.lsu_req_valid;
        grant_ifu_s = bus.ifu_req_valid;
      end
    end else begin
      grant_ifu_s = 1'b0;
      grant_lsu_s = 1'b0;
    end
  end

  // Transaction FSM with request latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      gnt_lsu_q       <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_wen_q       <= 1'b0;
      mem_addr_q      <= {AW{1'b0}};
      mem_wdata_q     <= {DW{1'b0}};
      mem_wmask_q     <= 8'h00;
`ifdef ROUND_ROBIN_EN
      last_lsu_q      <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_lsu_s) begin
            state_q         <= S_REQ;
            gnt_lsu_q       <= 1'b1;
            mem_req_valid_q <= 1'b1;
            mem_wen_q       <= bus.lsu_wen;
            mem_addr_q      <= bus.lsu_addr;
            mem_wdata_q     <= bus.lsu_wdata;
            // Loads never carry a byte mask onto the memory port
            mem_wmask_q     <= bus.lsu_wen ? bus.lsu_wmask : 8'h00;
`ifdef ROUND_ROBIN_EN
            last_lsu_q      <= 1'b1;
`endif
          end else if (grant_ifu_s) begin
            state_q         <= S_REQ;
            gnt_lsu_q       <= 1'b0;
            mem_req_valid_q <= 1'b1;
            mem_wen_q       <= 1'b0;
            mem_addr_q      <= bus.ifu_addr;
            mem_wdata_q     <= {DW{1'b0}};
            mem_wmask_q     <= 8'h00;
`ifdef ROUND_ROBIN_EN
            last_lsu_q      <= 1'b0;
`endif
          end else begin
            state_q         <= S_IDLE;
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) begin
            state_q         <= S_RESP;
            mem_req_valid_q <= 1'b0;
          end else begin
            state_q         <= S_REQ;
          end
        end
        S_RESP: begin
          if (bus.mem_rsp_valid) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_RESP;
          end
        end
        default: begin
          state_q         <= S_IDLE;
          mem_req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ifu_req_ready = grant_ifu_s;
  assign bus.lsu_req_ready = grant_lsu_s;

  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wmask     = mem_wmask_q;

  // Response forwarded in the same cycle it arrives, only to the owner
  assign bus.ifu_rsp_valid = (state_q == S_RESP) && bus.mem_rsp_valid && !gnt_lsu_q;
  assign bus.lsu_rsp_valid = (state_q == S_RESP) && bus.mem_rsp_valid &&  gnt_lsu_q;
  assign bus.ifu_rsp_data  = bus.mem_rsp_data;
  assign bus.lsu_rsp_data  = bus.mem_rsp_data;

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Self-checking bench for ysyx_24100005_mem_arbiter: directed scenarios plus
// randomized transactions checked against a transaction-level arbitration model.
module tb_ysyx_24100005_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_24100005_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  ysyx_24100005_mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  bit last_lsu; // model: most recent winner was the LSU

  // Reference tie-break rule: returns 1 when the LSU should win
  function automatic bit pick_lsu(bit iv, bit lv);
    if (iv && lv) return RR ? !last_lsu : 1'b1;
    return lv;
  endfunction

  task automatic idle_inputs();
    bus.ifu_req_valid = 1'b0; bus.ifu_addr  = 32'h0;
    bus.lsu_req_valid = 1'b0; bus.lsu_wen   = 1'b0;
    bus.lsu_addr      = 32'h0; bus.lsu_wdata = 32'h0; bus.lsu_wmask = 8'h00;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = 32'h0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_lsu = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({bus.mem_req_valid, bus.ifu_rsp_valid, bus.lsu_rsp_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_valids: got %b want 000", {bus.mem_req_valid, bus.ifu_rsp_valid, bus.lsu_rsp_valid});
    end
    vectors++;
    if ({bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== 73'h0) begin
      miscompares++;
      $display("FAIL reset_latches: got %h want 0", {bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_wmask});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_lsu = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.mem_req_valid, bus.ifu_req_ready, bus.lsu_req_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_idle: got %b want 000", {bus.mem_req_valid, bus.ifu_req_ready, bus.lsu_req_ready});
    end
  endtask

  task automatic test_ifu_read();
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0000;
    @(negedge clk);
    vectors++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL ifu_accept: got %b want 10", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    @(posedge clk); #1;
    last_lsu = 1'b0;
    bus.ifu_req_valid = 1'b0; bus.ifu_addr = 32'h0; bus.mem_req_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.mem_req_valid, bus.mem_wen, bus.mem_addr, bus.mem_wmask} !== {1'b1, 1'b0, 32'h8000_0000, 8'h00}) begin
      miscompares++;
      $display("FAIL ifu_memreq: got %h want %h", {bus.mem_req_valid, bus.mem_wen, bus.mem_addr, bus.mem_wmask},
               {1'b1, 1'b0, 32'h8000_0000, 8'h00});
    end
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL ifu_wait: got %b want 00", {bus.ifu_rsp_valid, bus.lsu_rsp_valid});
    end
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0010_0073;
    @(negedge clk);
    vectors++;
    if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rsp_data} !== {2'b10, 32'h0010_0073}) begin
      miscompares++;
      $display("FAIL ifu_rsp: got %h want %h", {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rsp_data}, {2'b10, 32'h0010_0073});
    end
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL ifu_pulse: got %b want 00", {bus.ifu_rsp_valid, bus.lsu_rsp_valid});
    end
  endtask

  task automatic test_lsu_store();
    logic [73:0] exp_f;
    exp_f = {1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F};
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b1; bus.lsu_wen = 1'b1; bus.lsu_addr = 32'h8000_1000;
    bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wmask = 8'h0F;
    @(negedge clk);
    vectors++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL store_accept: got %b want 01", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    @(posedge clk); #1;
    last_lsu = 1'b1;
    bus.lsu_req_valid = 1'b0; bus.lsu_wen = 1'b0; bus.lsu_addr = 32'h1234_0000;
    bus.lsu_wdata = 32'h0; bus.lsu_wmask = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_req_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.mem_req_valid, bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== exp_f) begin
        miscompares++;
        $display("FAIL store_fields[%0d]: got %h want %h", i,
                 {bus.mem_req_valid, bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_wmask}, exp_f);
      end
      @(posedge clk); #1;
    end
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = $urandom;
    @(negedge clk);
    vectors++;
    if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid} !== 2'b01) begin
      miscompares++;
      $display("FAIL store_rsp: got %b want 01", {bus.ifu_rsp_valid, bus.lsu_rsp_valid});
    end
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic test_lsu_load();
    logic [31:0] a;
    a = $urandom;
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b1; bus.lsu_wen = 1'b0; bus.lsu_addr = a; bus.lsu_wmask = 8'hFF;
    @(posedge clk); #1;
    last_lsu = 1'b1;
    bus.lsu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.mem_req_valid, bus.mem_wen, bus.mem_addr, bus.mem_wmask} !== {1'b1, 1'b0, a, 8'h00}) begin
      miscompares++;
      $display("FAIL load_fields: got %h want %h", {bus.mem_req_valid, bus.mem_wen, bus.mem_addr, bus.mem_wmask}, {1'b1, 1'b0, a, 8'h00});
    end
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h1234_5678;
    @(negedge clk);
    vectors++;
    if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.lsu_rsp_data} !== {2'b01, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL load_rsp: got %h want %h", {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.lsu_rsp_data}, {2'b01, 32'h1234_5678});
    end
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic test_arbitration();
    bit exp_lsu;
    apply_reset();
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1; bus.lsu_wen = 1'b0;
    bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hA5A5_0000;
    for (int i = 0; i < 4; i++) begin
      exp_lsu = RR ? (i % 2 == 1) : 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready} !== {!exp_lsu, exp_lsu}) begin
        miscompares++;
        $display("FAIL tie_grant[%0d]: got %b want %b", i, {bus.ifu_req_ready, bus.lsu_req_ready}, {!exp_lsu, exp_lsu});
      end
      @(posedge clk); #1;
      last_lsu = exp_lsu;
      @(negedge clk);
      vectors++;
      if ({bus.mem_req_valid, bus.ifu_req_ready, bus.lsu_req_ready} !== 3'b100) begin
        miscompares++;
        $display("FAIL tie_busy[%0d]: got %b want 100", i, {bus.mem_req_valid, bus.ifu_req_ready, bus.lsu_req_ready});
      end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid} !== {!exp_lsu, exp_lsu}) begin
        miscompares++;
        $display("FAIL tie_rsp[%0d]: got %b want %b", i, {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, {!exp_lsu, exp_lsu});
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_resp();
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0040;
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.mem_req_valid, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_addr} !== 35'h0) begin
      miscompares++;
      $display("FAIL rst_async: got %h want 0", {bus.mem_req_valid, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_addr});
    end
    @(negedge clk);
    rst = 1'b1;
    last_lsu = 1'b1;
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hBAD0_BAD0;
    @(negedge clk);
    vectors++;
    if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_late_rsp: got %b want 000", {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid});
    end
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0; bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0080;
    @(negedge clk);
    vectors++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_next_accept: got %b want 10", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    @(posedge clk); #1;
    last_lsu = 1'b0;
    bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0000_1111;
    @(negedge clk);
    vectors++;
    if ({bus.ifu_rsp_valid, bus.ifu_rsp_data} !== {1'b1, 32'h0000_1111}) begin
      miscompares++;
      $display("FAIL rst_next_rsp: got %h want %h", {bus.ifu_rsp_valid, bus.ifu_rsp_data}, {1'b1, 32'h0000_1111});
    end
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic test_idle_rsp();
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid, bus.ifu_req_ready, bus.lsu_req_ready} !== 5'b0) begin
        miscompares++;
        $display("FAIL idle_rsp[%0d]: got %b want 00000", i,
                 {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid, bus.ifu_req_ready, bus.lsu_req_ready});
      end
      @(posedge clk); #1;
    end
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic test_random();
    bit exp_lsu, iv, lv, lwen;
    logic [31:0] iaddr, laddr, lwdata, rdata;
    logic [7:0] lmask;
    logic [72:0] exp_f;
    logic [31:0] exp_wd;
    int unsigned r;
    for (int t = 0; t < 150; t++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        bus.mem_rsp_valid = 1'($urandom_range(0, 1)); bus.mem_rsp_data = $urandom;
        @(negedge clk);
        vectors++;
        if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid} !== 3'b000) begin
          miscompares++;
          $display("FAIL rnd_gap[%0d]: got %b want 000", t, {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid});
        end
        @(posedge clk); #1;
      end
      bus.mem_rsp_valid = 1'b0;
      r = $urandom_range(1, 3);
      iv = r[0]; lv = r[1];
      iaddr = $urandom; laddr = $urandom; lwdata = $urandom; lmask = 8'($urandom); lwen = 1'($urandom_range(0, 1));
      bus.ifu_req_valid = iv; bus.ifu_addr = iaddr;
      bus.lsu_req_valid = lv; bus.lsu_addr = laddr; bus.lsu_wdata = lwdata; bus.lsu_wmask = lmask; bus.lsu_wen = lwen;
      exp_lsu = pick_lsu(iv, lv);
      if (exp_lsu) exp_f = {lwen, laddr, (lwen ? lmask : 8'h00), 32'h0};
      else         exp_f = {1'b0, iaddr, 8'h00, 32'h0};
      exp_wd = exp_lsu ? lwdata : 32'h0;
      @(negedge clk);
      vectors++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready} !== {!exp_lsu, exp_lsu}) begin
        miscompares++;
        $display("FAIL rnd_grant[%0d]: got %b want %b", t, {bus.ifu_req_ready, bus.lsu_req_ready}, {!exp_lsu, exp_lsu});
      end
      @(posedge clk); #1;
      last_lsu = exp_lsu;
      for (int w = 0; w <= int'($urandom_range(0, 3)); w++) begin
        bus.ifu_req_valid = 1'($urandom_range(0, 1)); bus.ifu_addr = $urandom;
        bus.lsu_req_valid = 1'($urandom_range(0, 1)); bus.lsu_addr = $urandom; bus.lsu_wmask = 8'($urandom);
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.mem_req_valid, bus.mem_wen, bus.mem_addr, bus.mem_wmask, (exp_lsu ? bus.mem_wdata : 32'h0),
             bus.ifu_req_ready, bus.lsu_req_ready} !== {1'b1, exp_f[72:32], exp_wd, 2'b00}) begin
          miscompares++;
          $display("FAIL rnd_hold[%0d]: got %h want %h", t,
                   {bus.mem_req_valid, bus.mem_wen, bus.mem_addr, bus.mem_wmask, bus.mem_wdata, bus.ifu_req_ready, bus.lsu_req_ready},
                   {1'b1, exp_f[72:32], exp_wd, 2'b00});
        end
        @(posedge clk); #1;
      end
      bus.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
        @(negedge clk);
        vectors++;
        if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid} !== 3'b000) begin
          miscompares++;
          $display("FAIL rnd_rspwait[%0d]: got %b want 000", t, {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid});
        end
        @(posedge clk); #1;
      end
      rdata = $urandom;
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = rdata;
      @(negedge clk);
      vectors++;
      if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, (exp_lsu ? bus.lsu_rsp_data : bus.ifu_rsp_data)} !== {!exp_lsu, exp_lsu, rdata}) begin
        miscompares++;
        $display("FAIL rnd_rsp[%0d]: got %h want %h", t,
                 {bus.ifu_rsp_valid, bus.lsu_rsp_valid, (exp_lsu ? bus.lsu_rsp_data : bus.ifu_rsp_data)}, {!exp_lsu, exp_lsu, rdata});
      end
      @(posedge clk); #1;
      bus.mem_rsp_valid = 1'b0; bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    last_lsu = 1'b1;
    test_reset();
    test_ifu_read();
    test_lsu_store();
    test_lsu_load();
    test_arbitration();
    test_reset_in_resp();
    test_idle_rsp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
